// File: rtl/afisaj_pkg.sv
// Shared constants for the stopwatch 7-segment display driver:
// segment patterns (active-low, bit order {g,f,e,d,c,b,a}), digit indices
// and bus widths. Also a helper that turns a digit index into an anode mask.
package afisaj_pkg;

   localparam int BCD_W = 4;
   localparam int SEG_W = 7;
   localparam int AN_W  = 4;

   // Active-low segment patterns, {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Scan order: rightmost digit first
   localparam logic [1:0] IDX_SEC0 = 2'd0;
   localparam logic [1:0] IDX_SEC1 = 2'd1;
   localparam logic [1:0] IDX_MIN0 = 2'd2;
   localparam logic [1:0] IDX_MIN1 = 2'd3;

   // Active-low anode mask selecting a single digit
   function automatic logic [AN_W-1:0] an_select(input logic [1:0] idx);
      logic [AN_W-1:0] onehot;
      onehot = 4'b0001 << idx;
      return ~onehot;
   endfunction

endpackage

// File: rtl/afisaj_7seg_mux_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not valid BCD and show a dash (only segment g lit).
module bcd_to_7seg
   import afisaj_pkg::*;
(
   input  logic [BCD_W-1:0] i_bcd,
   output logic [SEG_W-1:0] o_seg
);

   // Map one nibble to its segment pattern
   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/afisaj_7seg_mux.sv
// Time-multiplexed 4-digit 7-segment driver for the stopwatch (MM:SS).
// One shared active-low segment bus, four active-low anodes, DP used as colon.
// Digits come from a snapshot taken at each frame boundary so a frame never
// mixes old and new values. While paused the display blinks frame-wise.
// Optional build macro AFISAJ_LEADING_ZERO_BLANK_EN blanks a zero tens-of-
// minutes digit (anode timing unchanged).
module afisaj_7seg_mux
   import afisaj_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64
)(
   input  logic             clk_out,
   input  logic             reset,
   input  logic [BCD_W-1:0] MIN_BCD0,
   input  logic [BCD_W-1:0] MIN_BCD1,
   input  logic [BCD_W-1:0] SEC_BCD0,
   input  logic [BCD_W-1:0] SEC_BCD1,
   input  logic             pauza,
   output logic [SEG_W-1:0] SEG,
   output logic [AN_W-1:0]  AN,
   output logic             DP
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [PW-1:0]      r_presc;
   logic [1:0]         r_idx;
   logic [4*BCD_W-1:0] r_snap;       // {MIN1, MIN0, SEC1, SEC0}
   logic               r_pauza;
   logic [FW-1:0]      r_frame;
   logic               r_blink_phase;
   logic [SEG_W-1:0]   r_seg;
   logic [AN_W-1:0]    r_an;
   logic               r_dp;

   logic               w_tick;
   logic               w_wrap;
   logic               w_dark;
   logic [BCD_W-1:0]   w_nibble;
   logic [SEG_W-1:0]   w_dec_seg;
   logic [SEG_W-1:0]   w_seg_next;

   assign w_tick = (r_presc == PRESC_LAST);
   assign w_wrap = w_tick && (r_idx == IDX_MIN1);
   assign w_dark = r_pauza && r_blink_phase;

   // Prescaler and digit scan index
   always_ff @(posedge clk_out) begin
      if (reset) begin
         r_presc <= '0;
         r_idx   <= IDX_SEC0;
      end else if (w_tick) begin
         r_presc <= '0;
         r_idx   <= r_idx + 2'd1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   // Capture all four digits together at the frame boundary
   always_ff @(posedge clk_out) begin
      if (reset) begin
         r_snap <= '0;
      end else if (w_wrap) begin
         r_snap <= {MIN_BCD1, MIN_BCD0, SEC_BCD1, SEC_BCD0};
      end
   end

   // Pause input register and frame-based blink phase; idle at phase 0 when running
   always_ff @(posedge clk_out) begin
      if (reset) begin
         r_pauza       <= 1'b0;
         r_frame       <= '0;
         r_blink_phase <= 1'b0;
      end else begin
         r_pauza <= pauza;
         if (!r_pauza) begin
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
         end else if (w_wrap) begin
            if (r_frame == FRAME_LAST) begin
               r_frame       <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_frame <= r_frame + 1'b1;
            end
         end
      end
   end

   // Select the snapshot nibble for the digit being scanned
   always_comb begin
      w_nibble = '0;
      case (r_idx)
         IDX_SEC0: w_nibble = r_snap[0*BCD_W +: BCD_W];
         IDX_SEC1: w_nibble = r_snap[1*BCD_W +: BCD_W];
         IDX_MIN0: w_nibble = r_snap[2*BCD_W +: BCD_W];
         IDX_MIN1: w_nibble = r_snap[3*BCD_W +: BCD_W];
         default:  w_nibble = '0;
      endcase
   end

   bcd_to_7seg u_dec (
      .i_bcd (w_nibble),
      .o_seg (w_dec_seg)
   );

   // Segment value for the current digit, with optional leading-zero blanking
   always_comb begin
      w_seg_next = w_dec_seg;
`ifdef AFISAJ_LEADING_ZERO_BLANK_EN
      if ((r_idx == IDX_MIN1) && (r_snap[3*BCD_W +: BCD_W] == '0)) begin
         w_seg_next = SEG_BLANK;
      end
`else
      w_seg_next = w_dec_seg;
`endif
   end

   // Registered pin drivers; blink only darkens anodes and colon
   always_ff @(posedge clk_out) begin
      if (reset) begin
         r_seg <= SEG_BLANK;
         r_an  <= '1;
         r_dp  <= 1'b1;
      end else begin
         r_seg <= w_seg_next;
         if (w_dark) begin
            r_an <= '1;
            r_dp <= 1'b1;
         end else begin
            r_an <= an_select(r_idx);
            r_dp <= (r_idx == IDX_MIN0) ? 1'b0 : 1'b1;
         end
      end
   end

   assign SEG = r_seg;
   assign AN  = r_an;
   assign DP  = r_dp;

endmodule
